// File: rtl/network_sequencer_if.sv
// Sample-path bundle between the sequencer (master) and the sample/layer fabric (slave).
interface network_sequencer_if #(
  parameter int W        = 16,
  parameter int DEPTH    = 4,
  parameter int N_LAYERS = 2,
  parameter int N_OUT    = 4
);
  logic                  sample_clk;
  logic [W-1:0]          sample_in;
  logic [DEPTH*W-1:0]    taps;
  logic [N_LAYERS-1:0]   layer_rst;
  logic [N_LAYERS-1:0]   layer_done;
  logic [N_OUT*W-1:0]    result;
  logic [N_OUT*W-1:0]    sample_out;
  logic                  busy;
  logic [7:0]            overrun_cnt;
  logic [7:0]            timeout_cnt;

  modport master (
    input  sample_clk, sample_in, layer_done, result,
    output taps, layer_rst, sample_out, busy, overrun_cnt, timeout_cnt
  );

  modport slave (
    output sample_clk, sample_in, layer_done, result,
    input  taps, layer_rst, sample_out, busy, overrun_cnt, timeout_cnt
  );
endinterface

// File: rtl/network_sequencer.sv
// Per-sample layer sequencer: shift sample into taps, pulse each layer in turn, latch scaled results.
// Taps/layer_rst[0] two cycles after the edge; edges while busy are dropped and counted (NETWORK_SEQ_SATURATE_EN clamps outputs).
module network_sequencer #(
  parameter int W         = 16,
  parameter int DEPTH     = 4,
  parameter int N_LAYERS  = 2,
  parameter int N_OUT     = 4,
  parameter int IN_SHIFT  = 2,
  parameter int OUT_SHIFT = 2,
  parameter int TIMEOUT   = 1023
) (
  input  logic                clk,
  input  logic                rst,
  network_sequencer_if.master bus
);
  localparam int KW = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int SW = W + OUT_SHIFT;

  typedef enum logic [2:0] {IDLE, SHIFT, START, RUN, LATCH} state_t;

  state_t               state_q, state_d;
  logic [KW-1:0]        k_q, k_d;
  logic [CW-1:0]        wait_q, wait_d;
  logic                 prev_sample_clk_q, prev_sample_clk_d;
  logic [DEPTH*W-1:0]   taps_q, taps_d;
  logic [N_OUT*W-1:0]   sample_out_q, sample_out_d;
  logic [7:0]           overrun_cnt_q, overrun_cnt_d;
  logic [7:0]           timeout_cnt_q, timeout_cnt_d;

  logic                 edge_det, done_k, last_layer, wait_expired;
  logic signed [W-1:0]  shifted_in;

  function automatic logic [W-1:0] scale(input logic [W-1:0] r);
`ifdef NETWORK_SEQ_SATURATE_EN
    logic signed [W-1:0]  rs;
    logic signed [SW-1:0] wide;
    rs   = $signed(r);
    wide = SW'(rs) <<< OUT_SHIFT;
    // In range only when every bit above the W-bit sign agrees with it.
    if ((&wide[SW-1:W-1]) || ~(|wide[SW-1:W-1]))
      return wide[W-1:0];
    return wide[SW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`else
    return r << OUT_SHIFT;
`endif
  endfunction

  always_comb begin
    prev_sample_clk_d = bus.sample_clk;
    edge_det          = bus.sample_clk & ~prev_sample_clk_q;
    done_k            = bus.layer_done[k_q];
    last_layer        = (k_q == KW'(N_LAYERS - 1));
    wait_expired      = (wait_q == CW'(TIMEOUT - 1));
    shifted_in        = $signed(bus.sample_in) >>> IN_SHIFT;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (edge_det) state_d = SHIFT;
      SHIFT:   state_d = START;
      START:   state_d = RUN;
      RUN: begin
        if (done_k)            state_d = last_layer ? LATCH : START;
        else if (wait_expired) state_d = IDLE;
      end
      LATCH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    k_d           = k_q;
    wait_d        = wait_q;
    taps_d        = taps_q;
    sample_out_d  = sample_out_q;
    overrun_cnt_d = overrun_cnt_q;
    timeout_cnt_d = timeout_cnt_q;

    unique case (state_q)
      SHIFT: begin
        for (int i = DEPTH - 1; i > 0; i--)
          taps_d[i*W +: W] = taps_q[(i-1)*W +: W];
        taps_d[W-1:0] = shifted_in;
        k_d           = '0;
      end
      START: wait_d = '0;
      RUN: begin
        if (done_k) begin
          if (!last_layer) k_d = k_q + 1'b1;
        end else if (wait_expired) begin
          if (timeout_cnt_q != 8'hFF) timeout_cnt_d = timeout_cnt_q + 8'd1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      LATCH: begin
        for (int j = 0; j < N_OUT; j++)
          sample_out_d[j*W +: W] = scale(bus.result[j*W +: W]);
      end
      default: ;
    endcase

    // Edges never restart an in-flight pass, including the LATCH cycle.
    if (edge_det && state_q != IDLE && overrun_cnt_q != 8'hFF)
      overrun_cnt_d = overrun_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    prev_sample_clk_q <= prev_sample_clk_d;
    if (rst) begin
      k_q           <= '0;
      wait_q        <= '0;
      taps_q        <= '0;
      sample_out_q  <= '0;
      overrun_cnt_q <= '0;
      timeout_cnt_q <= '0;
    end else begin
      k_q           <= k_d;
      wait_q        <= wait_d;
      taps_q        <= taps_d;
      sample_out_q  <= sample_out_d;
      overrun_cnt_q <= overrun_cnt_d;
      timeout_cnt_q <= timeout_cnt_d;
    end
  end

  always_comb begin
    bus.layer_rst = '0;
    if (state_q == START) bus.layer_rst[k_q] = 1'b1;
    bus.busy        = (state_q != IDLE);
    bus.taps        = taps_q;
    bus.sample_out  = sample_out_q;
    bus.overrun_cnt = overrun_cnt_q;
    bus.timeout_cnt = timeout_cnt_q;
  end
endmodule

// File: tb/tb_network_sequencer.sv
// Randomized scoreboard bench for network_sequencer; pass-level reference model in plain arithmetic.
module tb_network_sequencer;
  localparam int W = 16, DEPTH = 4, NL = 2, NO = 4, IN_SHIFT = 2, OUT_SHIFT = 2, TO = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  network_sequencer_if #(.W(W), .DEPTH(DEPTH), .N_LAYERS(NL), .N_OUT(NO)) bus();

  network_sequencer #(
    .W(W), .DEPTH(DEPTH), .N_LAYERS(NL), .N_OUT(NO),
    .IN_SHIFT(IN_SHIFT), .OUT_SHIFT(OUT_SHIFT), .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic [DEPTH-1:0][W-1:0] taps;
    logic [NO-1:0][W-1:0]    outs;
    logic [7:0]              ovr;
    logic [7:0]              tmo;
    logic [15:0]             dur;
    logic [NL-1:0][7:0]      pulses;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0, n_bad = 0;
  bit   mon_en = 1'b0;

  int m_taps[DEPTH];
  int m_out[NO];
  int m_ovr, m_tmo;
  int p_res[NO];
  int p_dly[NL];
  int dly[NL];
  int cnt[NL];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int scale_ref(input int r);
    int v;
    v = r * (1 << OUT_SHIFT);
`ifdef NETWORK_SEQ_SATURATE_EN
    if (v > (1 << (W - 1)) - 1) v = (1 << (W - 1)) - 1;
    if (v < -(1 << (W - 1)))    v = -(1 << (W - 1));
`else
    v = v & ((1 << W) - 1);
    if (v >= (1 << (W - 1))) v = v - (1 << W);
`endif
    return v;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < DEPTH; i++) m_taps[i] = 0;
    for (int j = 0; j < NO; j++) m_out[j] = 0;
    m_ovr = 0;
    m_tmo = 0;
  endfunction

  // Layer stand-ins: done rises d cycles after the pulse and is held until the next pulse.
  initial begin
    bus.layer_done = '0;
    for (int k = 0; k < NL; k++) begin dly[k] = 1; cnt[k] = 0; end
    forever begin
      @(negedge clk);
      for (int k = 0; k < NL; k++) begin
        if (bus.layer_rst[k]) begin
          cnt[k] = dly[k];
          bus.layer_done[k] = (dly[k] > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
        end else if (cnt[k] > 0) begin
          cnt[k]--;
          bus.layer_done[k] = (cnt[k] == 0);
        end
      end
    end
  end

  // Monitor: a falling busy marks the end of a pass; compare against the oldest expectation.
  initial begin
    exp_t e;
    int   busy_cyc;
    int   pulses[NL];
    bit   prev_busy;
    busy_cyc = 0;
    prev_busy = 1'b0;
    for (int k = 0; k < NL; k++) pulses[k] = 0;
    forever begin
      @(negedge clk);
      if (rst || !mon_en) begin
        busy_cyc  = 0;
        prev_busy = 1'b0;
        for (int k = 0; k < NL; k++) pulses[k] = 0;
      end else begin
        if (bus.busy) begin
          busy_cyc++;
          for (int k = 0; k < NL; k++) if (bus.layer_rst[k]) pulses[k]++;
          check("layer_rst_onehot", 128'($onehot0(bus.layer_rst)), 128'(1));
        end else begin
          check("layer_rst_idle", 128'(bus.layer_rst), 128'(0));
          if (prev_busy) begin
            if (sb.size() == 0) begin
              check("unexpected_pass_end", 128'(1), 128'(0));
            end else begin
              e = sb.pop_front();
              check("taps",        128'(bus.taps),        128'(e.taps));
              check("sample_out",  128'(bus.sample_out),  128'(e.outs));
              check("overrun_cnt", 128'(bus.overrun_cnt), 128'(e.ovr));
              check("timeout_cnt", 128'(bus.timeout_cnt), 128'(e.tmo));
              check("busy_cycles", 128'(busy_cyc),        128'(e.dur));
              for (int k = 0; k < NL; k++)
                check("layer_pulses", 128'(pulses[k]), 128'(e.pulses[k]));
            end
            busy_cyc = 0;
            for (int k = 0; k < NL; k++) pulses[k] = 0;
          end
        end
        prev_busy = bus.busy;
      end
    end
  end

  // One pass: edge in cycle 0, optional extra edge near cycle x_req (0 = none), idle afterwards.
  task automatic run_pass(input int s, input int x_req);
    exp_t e;
    int   dur, tl, x;
    e   = '0;
    dur = 1;
    tl  = -1;
    for (int k = 0; k < NL; k++) begin
      if (tl < 0) begin
        e.pulses[k] = 8'd1;
        if (p_dly[k] == 0 || p_dly[k] > TO) begin
          tl  = k;
          dur = dur + 1 + TO;
        end else begin
          dur = dur + 1 + p_dly[k];
        end
      end
    end
    if (tl < 0) dur = dur + 1;

    for (int i = DEPTH - 1; i > 0; i--) m_taps[i] = m_taps[i-1];
    m_taps[0] = s >>> IN_SHIFT;
    if (tl < 0) begin
      for (int j = 0; j < NO; j++) m_out[j] = scale_ref(p_res[j]);
    end else if (m_tmo < 255) begin
      m_tmo++;
    end
    x = (x_req == 0) ? 0 : (x_req < 2) ? 2 : (x_req > dur) ? dur : x_req;
    if (x != 0 && m_ovr < 255) m_ovr++;

    for (int i = 0; i < DEPTH; i++) e.taps[i] = W'(m_taps[i]);
    for (int j = 0; j < NO; j++) e.outs[j] = W'(m_out[j]);
    e.ovr = 8'(m_ovr);
    e.tmo = 8'(m_tmo);
    e.dur = 16'(dur);
    sb.push_back(e);

    for (int k = 0; k < NL; k++) dly[k] = p_dly[k];
    for (int j = 0; j < NO; j++) bus.result[j*W +: W] = W'(p_res[j]);
    for (int c = 0; c <= dur + 2; c++) begin
      @(negedge clk);
      bus.sample_clk = (c == 0) || (x != 0 && c == x);
      bus.sample_in  = (c <= 1) ? W'(s) : W'($urandom);
    end
  endtask

  function automatic int rand_sample();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  initial begin
    rst            = 1'b1;
    bus.sample_clk = 1'b1;
    bus.sample_in  = '0;
    bus.result     = '0;
    model_clear();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rst_busy",       128'(bus.busy),        128'(0));
      check("rst_layer_rst",  128'(bus.layer_rst),   128'(0));
      check("rst_taps",       128'(bus.taps),        128'(0));
      check("rst_sample_out", 128'(bus.sample_out),  128'(0));
      check("rst_overrun",    128'(bus.overrun_cnt), 128'(0));
      check("rst_timeout",    128'(bus.timeout_cnt), 128'(0));
    end
    bus.sample_clk = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;

    p_res = '{1000, -500, 7, -7};
    p_dly = '{3, 3};
    run_pass(20000, 0);

    for (int i = 1; i <= 4; i++) begin
      p_dly = '{int'($urandom_range(1, 4)), int'($urandom_range(1, 4))};
      run_pass(4 * i, 0);
    end

    p_dly = '{3, 3};
    run_pass(-12345, 8);

    p_dly = '{0, 3};
    run_pass(100, 0);
    p_dly = '{2, 2};
    run_pass(-100, 0);

    p_res = '{10000, -10000, 8191, -8192};
    p_dly = '{1, 1};
    run_pass(32767, 0);

    p_dly = '{TO, 1};
    run_pass(-32768, 0);
    p_dly = '{1, TO + 1};
    run_pass(555, 0);
    p_dly = '{2, 2};
    run_pass(556, 1000);

    for (int n = 0; n < 40; n++) begin
      for (int k = 0; k < NL; k++) begin
        case ($urandom_range(0, 9))
          0:       p_dly[k] = 0;
          1:       p_dly[k] = TO;
          2:       p_dly[k] = TO + 1;
          default: p_dly[k] = int'($urandom_range(1, 5));
        endcase
      end
      for (int j = 0; j < NO; j++) p_res[j] = rand_sample();
      run_pass(rand_sample(), ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 40)) : 0);
    end

    check("scoreboard_drained", 128'(sb.size()), 128'(0));

    mon_en = 1'b0;
    p_dly  = '{8, 8};
    for (int k = 0; k < NL; k++) dly[k] = p_dly[k];
    @(negedge clk);
    bus.sample_clk = 1'b1;
    bus.sample_in  = W'(4000);
    repeat (5) @(negedge clk);
    bus.sample_clk = 1'b0;
    check("midpass_busy_before", 128'(bus.busy), 128'(1));
    rst = 1'b1;
    @(negedge clk);
    check("midpass_busy",       128'(bus.busy),        128'(0));
    check("midpass_layer_rst",  128'(bus.layer_rst),   128'(0));
    check("midpass_taps",       128'(bus.taps),        128'(0));
    check("midpass_sample_out", 128'(bus.sample_out),  128'(0));
    check("midpass_counters",   128'({bus.overrun_cnt, bus.timeout_cnt}), 128'(0));
    rst = 1'b0;
    model_clear();
    @(negedge clk);
    mon_en = 1'b1;
    p_res = '{1, -1, 2, -2};
    p_dly = '{2, 3};
    run_pass(-4, 0);
    check("scoreboard_final", 128'(sb.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
